// File: rtl/sliced_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock with the carry held in a register
// between slices. Valid/ready handshakes on both the operand side and the result side.
module sliced_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for an operation, in_ready = 1
  // BUSY  | adding one slice per clock, busy = 1
  // DONE  | result presented, out_valid = 1 until out_ready

  localparam int NSLICE = (CHUNK >= 1) ? WIDTH / CHUNK : 1;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("sliced_adder: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [CHUNK:0]   slice_res;
  logic             last_slice;
  logic             accept;
  int               base;

  assign accept     = in_valid && in_ready;
  assign last_slice = (idx == IW'(NSLICE - 1));
  assign base       = int'(idx) * CHUNK;
  assign slice_res  = {1'b0, op_a[base +: CHUNK]} + {1'b0, op_b[base +: CHUNK]}
                    + {{CHUNK{1'b0}}, carry};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last_slice) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1; c_in is ignored in that mode.
      op_a  <= a;
      op_b  <= sub ? ~b : b;
      carry <= sub ? 1'b1 : c_in;
      idx   <= '0;
    end else if (state == BUSY) begin
      sum[base +: CHUNK] <= slice_res[CHUNK-1:0];
      carry              <= slice_res[CHUNK];
      if (last_slice) begin
        idx   <= '0;
        c_out <= slice_res[CHUNK];
        ovf   <= (op_a[WIDTH-1] == op_b[WIDTH-1]) && (slice_res[CHUNK-1] != op_a[WIDTH-1]);
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sliced_adder.sv
// Bench for sliced_adder: directed and random operations on a 16/4 instance plus a
// single-slice 16/16 instance, checked against an integer-arithmetic reference.
module tb_sliced_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [15:0] a = '0, b = '0;
  logic        c_in = 1'b0, sub = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [15:0] sum;
  logic        c_out, ovf, busy;

  logic        s_in_valid = 1'b0, s_in_ready;
  logic [15:0] s_a = '0, s_b = '0;
  logic        s_out_valid, s_out_ready = 1'b0;
  logic [15:0] s_sum;
  logic        s_c_out, s_ovf, s_busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sliced_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf), .busy(busy)
  );

  sliced_adder #(.WIDTH(16), .CHUNK(16)) dut_single (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .c_in(1'b0), .sub(1'b0), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .sum(s_sum), .c_out(s_c_out), .ovf(s_ovf), .busy(s_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: returns {ovf, c_out, sum} from plain integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mc, input logic ms);
    int unsigned full;
    int          sa, sb, sres;
    logic        cy, v;
    sa = $signed(ma);
    sb = $signed(mb);
    if (ms) begin
      full = 32'(ma) + 32'd65536 - 32'(mb);
      sres = sa - sb;
    end else begin
      full = 32'(ma) + 32'(mb) + 32'(mc);
      sres = sa + sb + int'(mc);
    end
    cy = (full >= 32'd65536);
    v  = (sres > 32767) || (sres < -32768);
    return {v, cy, full[15:0]};
  endfunction

  // One full operation on the 16/4 instance, with optional backpressure and
  // input disturbance while the operation is in flight.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                        input logic ts, input int stall, input bit disturb);
    logic [17:0] exp;
    int n;
    exp = model(ta, tb, tc, ts);
    @(negedge clk);
    a = ta; b = tb; c_in = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b0;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = disturb;
    n = 0;
    while (!out_valid && n < 20) begin
      check("busy_in_ready", 32'(in_ready), 32'd0);
      check("busy_flag", 32'(busy), 32'd1);
      @(posedge clk); #1;
      n++;
      if (disturb) begin
        a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
      end
    end
    check("latency", 32'(n), 32'd4);
    check("sum", 32'(sum), 32'(exp[15:0]));
    check("c_out", 32'(c_out), 32'(exp[16]));
    check("ovf", 32'(ovf), 32'(exp[17]));
    repeat (stall) begin
      @(posedge clk); #1;
      if (disturb) begin a = 16'($urandom); b = 16'($urandom); end
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_result", {14'd0, ovf, c_out, sum}, {14'd0, exp});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
    check("post_busy", 32'(busy), 32'd0);
    check("post_retain", {14'd0, ovf, c_out, sum}, {14'd0, exp});
  endtask

  initial begin
    int last_pulse, pulses, cyc;

    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outputs", {13'd0, busy, ovf, c_out, sum}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op(16'h00F9, 16'h000D, 1'b0, 1'b0, 0, 1'b0);
    check("t1_sum", 32'(sum), 32'h0106);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0, 1'b0);
    check("t2_carry", {31'd0, c_out}, 32'd1);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    check("t2_ovf", {15'd0, ovf, sum}, {15'd1, 16'h8000});
    run_op(16'h0003, 16'h0005, 1'b0, 1'b1, 0, 1'b0);
    check("t3_sub", {14'd0, ovf, c_out, sum}, {16'd0, 16'hFFFE});
    run_op(16'h0003, 16'h0005, 1'b1, 1'b1, 1, 1'b0);
    check("t3_sub_cin", 32'(sum), 32'hFFFE);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, 1'b0);
    check("t3_sub_ovf", {14'd0, ovf, c_out, sum}, {14'd0, 2'b11, 16'h7FFF});
    run_op(16'h1357, 16'h2468, 1'b1, 1'b0, 3, 1'b1);

    for (int i = 0; i < 20; i++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)), 1'($urandom));

    // Abort an operation after two BUSY cycles.
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; sub = 1'b0; c_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      check("abort_no_result", 32'(out_valid), 32'd0);
    end
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b0);
    check("t5_sum", {15'd0, c_out, sum}, {16'd0, 16'h5555});

    // Single-slice instance: one-edge latency.
    @(negedge clk);
    s_a = 16'hFFFF; s_b = 16'h0001; s_in_valid = 1'b1;
    @(posedge clk); #1; s_in_valid = 1'b0;
    check("s_not_yet", 32'(s_out_valid), 32'd0);
    @(posedge clk); #1;
    check("s_latency", 32'(s_out_valid), 32'd1);
    check("s_result", {15'd0, s_c_out, s_sum}, {15'd0, 1'b1, 16'h0000});
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    check("s_handshake", 32'(s_out_valid), 32'd0);

    // Back-to-back with out_ready tied high: one result every 3 cycles.
    s_a = 16'h1234; s_b = 16'h0F0F; s_in_valid = 1'b1;
    last_pulse = -1; pulses = 0;
    for (cyc = 0; cyc < 16; cyc++) begin
      @(posedge clk); #1;
      if (s_out_valid) begin
        check("s_b2b_sum", 32'(s_sum), 32'h2143);
        if (last_pulse >= 0) check("s_b2b_period", 32'(cyc - last_pulse), 32'd3);
        last_pulse = cyc;
        pulses++;
      end
    end
    check("s_b2b_pulses", 32'(pulses), 32'd5);
    s_in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sliced_adder.md
Name: sliced_adder

Overview:
- Parametrised multi-cycle adder/subtractor; successor to the fixed 4-bit ripple full adder.
- Adds two WIDTH-bit operands CHUNK bits per clock, carrying between slices in a register.
- Supports add and subtract modes.
- Reports carry-out and signed overflow.
- Uses valid/ready handshakes on input and output, so it can sit between pipeline stages where a wide single-cycle carry chain would break timing.

Parameters:
- WIDTH, 16, operand and result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits added per clock. NSLICE = WIDTH/CHUNK; CHUNK = WIDTH is legal and gives single-slice operation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and mode presented.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in; used in add mode only.
- sub  input  1  0 = A+B+c_in; 1 = A-B.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- c_out  output  1  carry out of bit WIDTH-1. In sub mode, 1 means no borrow.
- ovf  output  1  signed two's-complement overflow.
- busy  output  1  high in BUSY state.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low, and acts immediately on rst_n falling.
  - In reset: state = IDLE; sum = 0, c_out = 0, ovf = 0, out_valid = 0, busy = 0; slice index and carry register = 0.
  - in_ready is decoded from state, so it reads 1 during and after reset.
- States:
  - IDLE: in_ready = 1.
  - BUSY: in_ready = 0, busy = 1.
  - DONE: out_valid = 1, in_ready = 0.
- IDLE -> BUSY on in_valid && in_ready at a rising edge. At that edge the block latches:
  - A into an operand register.
  - B' into an operand register, where B' = sub ? ~b : b.
  - The carry register, loaded with sub ? 1 : c_in.
  - Slice index = 0.
- BUSY, each cycle at slice index i:
  - {carry, sum[i*CHUNK +: CHUNK]} <= A_slice + B'_slice + carry.
  - i increments.
  - On the edge processing slice NSLICE-1:
    - c_out <= final carry.
    - ovf <= (A[MSB] == B'[MSB]) && (result[MSB] != A[MSB]).
    - State -> DONE.
- Latency: accept at edge k gives out_valid high after edge k+NSLICE.
- DONE: sum, c_out and ovf hold stable while out_valid = 1 && out_ready = 0, for any number of cycles.
  - out_valid && out_ready at an edge moves the state to IDLE.
  - sum, c_out and ovf retain their values after the result handshake until the next operation overwrites them.
- Input handling:
  - a, b, c_in and sub are sampled only at accept; changes during BUSY or DONE are ignored.
  - in_valid while in_ready = 0 is ignored, and no operation is queued.
- Throughput: a new operation is accepted no earlier than the edge after the result handshake, giving a minimum of NSLICE+2 cycles per operation.
- Width rules: c_out is the true carry out of WIDTH bits. sum wraps modulo 2^WIDTH.
- Reset mid-operation: any state aborts to IDLE with all outputs cleared. No out_valid is produced for the aborted operation.
- Parameter check: elaboration fails if WIDTH % CHUNK != 0 or CHUNK < 1.

Test Plan:
All scenarios use WIDTH = 16, CHUNK = 4 unless noted.
1. Add, no overflow: a = 0x00F9, b = 0x000D, c_in = 0, sub = 0.
   - sum = 0x0106, c_out = 0, ovf = 0.
   - out_valid rises exactly 4 edges after accept; in_ready is 0 throughout.
2. Carry chain: a = 0xFFFF, b = 0xFFFF, c_in = 1, sub = 0.
   - sum = 0xFFFF, c_out = 1, ovf = 0.
   - Separately, a = 0x7FFF, b = 0x0001, c_in = 0: sum = 0x8000, c_out = 0, ovf = 1.
3. Subtract:
   - a = 0x0003, b = 0x0005, sub = 1: sum = 0xFFFE, c_out = 0, ovf = 0.
   - a = 0x8000, b = 0x0001, sub = 1: sum = 0x7FFF, c_out = 1, ovf = 1.
   - Changing c_in has no effect in sub mode.
4. Backpressure and input isolation:
   - Hold out_ready = 0 for 3 cycles in DONE: sum, c_out and ovf stay stable and in_ready = 0.
   - Toggle a, b and in_valid during BUSY and DONE: the result is unchanged and no extra operation starts.
5. Reset mid-BUSY:
   - Drop rst_n after 2 BUSY cycles: out_valid = 0, sum = 0 and busy = 0 immediately, and in_ready = 1.
   - After release, a = 0x1234, b = 0x4321 gives sum = 0x5555, c_out = 0.
6. Single-slice configuration, CHUNK = 16: a = 0xFFFF, b = 0x0001.
   - sum = 0x0000, c_out = 1.
   - out_valid 1 edge after accept.
   - Back-to-back operations with out_ready tied to 1 run at 3 cycles per operation.
